// File: rtl/lbus_pkg.sv
// Shared local-bus constants and the write-arbiter state encoding.
package lbus_pkg;

    localparam logic [1:0] LBUS_OP_IDLE = 2'b00;
    localparam logic [1:0] LBUS_OP_WR   = 2'b01;
    localparam logic [1:0] LBUS_OP_RD   = 2'b10;

    localparam int NUM_CHL = 4;
    localparam int CHL_W   = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/lbus_rr_pick.sv
// Combinational 4-way round-robin picker: first requester after 'last', wrapping.
module lbus_rr_pick
    import lbus_pkg::*;
(
    input  logic [NUM_CHL-1:0] req,
    input  logic [CHL_W-1:0]   last,
    output logic [NUM_CHL-1:0] gnt_onehot,
    output logic [CHL_W-1:0]   gnt_idx,
    output logic               any
);

    logic [CHL_W-1:0] cand;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_CHL; i++) begin
            cand = last + CHL_W'(i);
            if (!any && req[cand]) begin
                any              = 1'b1;
                gnt_idx          = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lbus_wr_arbiter.sv
// Credit-limited round-robin arbiter for the local bus master write path,
// plus read-side demux, busy fold and a drain handshake.
module lbus_wr_arbiter
    import lbus_pkg::*;
#(
    parameter int BUF_DEPTH = 3,
    parameter int CRD_W     = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NUM_CHL-1:0]   chl_en,
    input  logic [NUM_CHL-1:0]   req_valid,
    input  logic [8*NUM_CHL-1:0] req_data,
    output logic [NUM_CHL-1:0]   req_ready,
    output logic [7:0]           mst_rx_data,
    output logic                 mst_rx_data_valid,
    output logic [CHL_W-1:0]     mst_rx_chl,
    input  logic                 mon_lbus_en,
    input  logic [1:0]           mon_lbus_op,
    input  logic [7:0]           mst_tx_data,
    input  logic                 mst_tx_data_valid,
    input  logic [CHL_W-1:0]     mst_tx_chl,
    output logic [7:0]           chl_rd_data,
    output logic [NUM_CHL-1:0]   chl_rd_valid,
    input  logic [NUM_CHL-1:0]   chl_busy,
    output logic                 mst_tx_busy,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 err_crd
);

    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(BUF_DEPTH);
    localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);

    arb_state_t         state_q, state_d;
    logic [CRD_W-1:0]   credits_q, credits_d;
    logic [CHL_W-1:0]   rr_last_q;
    logic [NUM_CHL-1:0] pick_onehot;
    logic [CHL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               wr_strobe;
    logic               grant;
    logic               crd_overflow;

    lbus_rr_pick u_pick (
        .req        (req_valid & chl_en),
        .last       (rr_last_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    assign wr_strobe   = mon_lbus_en && (mon_lbus_op == LBUS_OP_WR);
    assign grant       = (state_q == ST_RUN) && !drain_req && (credits_q != '0) && pick_any;
    assign req_ready   = grant ? pick_onehot : '0;
    assign mst_tx_busy = |chl_busy;

    // A grant consumes a buffer slot and a bus write strobe frees one; both cancel.
    always_comb begin
        credits_d    = credits_q;
        crd_overflow = 1'b0;
        if (grant && !wr_strobe) begin
            credits_d = credits_q - CRD_ONE;
        end else if (!grant && wr_strobe) begin
            if (credits_q == CRD_MAX) crd_overflow = 1'b1;
            else                      credits_d    = credits_q + CRD_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (drain_req)              state_d = ST_DRAIN;
                else if (credits_d == '0)   state_d = ST_STALL;
            end
            ST_STALL: begin
                if (drain_req)              state_d = ST_DRAIN;
                else if (credits_d != '0)   state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (credits_q == CRD_MAX && !mst_rx_data_valid) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!drain_req)             state_d = ST_RUN;
            end
            default:                        state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q           <= ST_RUN;
            credits_q         <= CRD_MAX;
            rr_last_q         <= '1;
            err_crd           <= 1'b0;
            drain_done        <= 1'b0;
            mst_rx_data       <= '0;
            mst_rx_chl        <= '0;
            mst_rx_data_valid <= 1'b0;
            chl_rd_data       <= '0;
            chl_rd_valid      <= '0;
        end else begin
            state_q           <= state_d;
            credits_q         <= credits_d;
            err_crd           <= err_crd | crd_overflow;
            drain_done        <= (state_q == ST_DRAIN) && (state_d == ST_DONE);
            mst_rx_data_valid <= grant;
            if (grant) begin
                rr_last_q   <= pick_idx;
                mst_rx_chl  <= pick_idx;
                mst_rx_data <= req_data[{pick_idx, 3'b000} +: 8];
            end
            if (mst_tx_data_valid) chl_rd_data <= mst_tx_data;
            chl_rd_valid <= mst_tx_data_valid ? (NUM_CHL'(1) << mst_tx_chl) : '0;
        end
    end

endmodule

// File: tb/tb_lbus_wr_arbiter.sv
// Self-checking bench for lbus_wr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a credit/round-robin reference model.
module tb_lbus_wr_arbiter;
    import lbus_pkg::*;

    logic        Clk;
    logic        Reset;
    logic [3:0]  chl_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  mst_rx_data;
    logic        mst_rx_data_valid;
    logic [1:0]  mst_rx_chl;
    logic        mon_lbus_en;
    logic [1:0]  mon_lbus_op;
    logic [7:0]  mst_tx_data;
    logic        mst_tx_data_valid;
    logic [1:0]  mst_tx_chl;
    logic [7:0]  chl_rd_data;
    logic [3:0]  chl_rd_valid;
    logic [3:0]  chl_busy;
    logic        mst_tx_busy;
    logic        drain_req;
    logic        drain_done;
    logic        err_crd;

    lbus_wr_arbiter #(.BUF_DEPTH(3), .CRD_W(2)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .chl_en            (chl_en),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .mst_rx_data       (mst_rx_data),
        .mst_rx_data_valid (mst_rx_data_valid),
        .mst_rx_chl        (mst_rx_chl),
        .mon_lbus_en       (mon_lbus_en),
        .mon_lbus_op       (mon_lbus_op),
        .mst_tx_data       (mst_tx_data),
        .mst_tx_data_valid (mst_tx_data_valid),
        .mst_tx_chl        (mst_tx_chl),
        .chl_rd_data       (chl_rd_data),
        .chl_rd_valid      (chl_rd_valid),
        .chl_busy          (chl_busy),
        .mst_tx_busy       (mst_tx_busy),
        .drain_req         (drain_req),
        .drain_done        (drain_done),
        .err_crd           (err_crd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] ready_s;
    logic       busy_s;

    localparam logic [31:0] BYTES = {8'h3C, 8'hA5, 8'h21, 8'h10};

    typedef struct {
        logic [3:0] en;
        logic [3:0] req;
        logic       w;
        logic       txv;
        logic [1:0] txc;
        logic [7:0] txd;
        logic [3:0] busy;
        logic [3:0] x_ready;
        logic       x_busy;
        logic       x_rxv;
        logic [1:0] x_rxc;
        logic [7:0] x_rxd;
        logic [3:0] x_rdv;
        logic [7:0] x_rdd;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven just after a rising edge; combinational outputs are sampled
    // 1 time unit later, registered outputs 1 time unit after the next rising edge.
    task automatic cycle();
        #1;
        ready_s = req_ready;
        busy_s  = mst_tx_busy;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        chl_en            = 4'hF;
        req_valid         = 4'h0;
        req_data          = BYTES;
        mon_lbus_en       = 1'b0;
        mon_lbus_op       = LBUS_OP_WR;
        mst_tx_data       = 8'h00;
        mst_tx_data_valid = 1'b0;
        mst_tx_chl        = 2'd0;
        chl_busy          = 4'h0;
        drain_req         = 1'b0;
    endtask

    // Reset is applied with whatever traffic is present, so in-flight bytes must be dropped.
    task automatic do_reset(input string tag);
        Reset = 1'b1;
        cycle();
        cycle();
        check({tag, "_rst_rx_valid"}, mst_rx_data_valid, 0);
        check({tag, "_rst_rd_valid"}, chl_rd_valid, 0);
        check({tag, "_rst_err"}, err_crd, 0);
        check({tag, "_rst_drain_done"}, drain_done, 0);
        idle_inputs();
        Reset = 1'b0;
    endtask

    function automatic vec_t mk(
        input logic [3:0] en, input logic [3:0] req, input logic w,
        input logic txv, input logic [1:0] txc, input logic [7:0] txd, input logic [3:0] busy,
        input logic [3:0] x_ready, input logic x_busy, input logic x_rxv,
        input logic [1:0] x_rxc, input logic [7:0] x_rxd,
        input logic [3:0] x_rdv, input logic [7:0] x_rdd);
        vec_t v;
        v.en = en; v.req = req; v.w = w; v.txv = txv; v.txc = txc; v.txd = txd; v.busy = busy;
        v.x_ready = x_ready; v.x_busy = x_busy; v.x_rxv = x_rxv; v.x_rxc = x_rxc;
        v.x_rxd = x_rxd; v.x_rdv = x_rdv; v.x_rdd = x_rdd;
        return v;
    endfunction

    initial begin
        int g;
        int pulses;
        int first_pulse;
        int m_cred;
        int m_last;
        int w;
        logic m_err;
        logic wr;
        logic [3:0] elig;
        logic [3:0] exp_ready;
        logic [1:0] exp_rxc;
        logic [7:0] exp_rxd;
        logic [3:0] exp_rdv;
        logic [7:0] exp_rdd;

        //        en     req    w     txv   txc   txd    busy  | ready  bsy  rxv  rxc   rxd    rdv    rdd
        tbl[0] = mk(4'hF, 4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0,   4'h1, 1'b0, 1'b1, 2'd0, 8'h10, 4'h0, 8'h00);
        tbl[1] = mk(4'hF, 4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0,   4'h2, 1'b0, 1'b1, 2'd1, 8'h21, 4'h0, 8'h00);
        tbl[2] = mk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 8'h00, 4'h4,   4'h4, 1'b1, 1'b1, 2'd2, 8'hA5, 4'h0, 8'h00);
        tbl[3] = mk(4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 8'h5C, 4'h0,   4'h8, 1'b0, 1'b1, 2'd3, 8'h3C, 4'h8, 8'h5C);
        tbl[4] = mk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 8'h00, 4'h0,   4'h1, 1'b0, 1'b1, 2'd0, 8'h10, 4'h0, 8'h5C);
        tbl[5] = mk(4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 8'h77, 4'h9,   4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 4'h2, 8'h77);
        tbl[6] = mk(4'hE, 4'h1, 1'b1, 1'b0, 2'd0, 8'h00, 4'h0,   4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 8'h77);
        tbl[7] = mk(4'hE, 4'h1, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0,   4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 8'h77);
        tbl[8] = mk(4'hE, 4'h5, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0,   4'h4, 1'b0, 1'b1, 2'd2, 8'hA5, 4'h0, 8'h77);
        tbl[9] = mk(4'hF, 4'h0, 1'b0, 1'b1, 2'd0, 8'hC3, 4'h0,   4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 4'h1, 8'hC3);

        idle_inputs();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        do_reset("init");

        // Fairness, write strobes from cycle 2, read demux, busy fold and channel mask.
        for (int i = 0; i < 10; i++) begin
            chl_en            = tbl[i].en;
            req_valid         = tbl[i].req;
            mon_lbus_en       = tbl[i].w;
            mst_tx_data_valid = tbl[i].txv;
            mst_tx_chl        = tbl[i].txc;
            mst_tx_data       = tbl[i].txd;
            chl_busy          = tbl[i].busy;
            cycle();
            check($sformatf("vec%0d_ready", i), ready_s, tbl[i].x_ready);
            check($sformatf("vec%0d_tx_busy", i), busy_s, tbl[i].x_busy);
            check($sformatf("vec%0d_rx_valid", i), mst_rx_data_valid, tbl[i].x_rxv);
            if (tbl[i].x_rxv) begin
                check($sformatf("vec%0d_rx_chl", i), mst_rx_chl, tbl[i].x_rxc);
                check($sformatf("vec%0d_rx_data", i), mst_rx_data, tbl[i].x_rxd);
            end
            check($sformatf("vec%0d_rd_valid", i), chl_rd_valid, tbl[i].x_rdv);
            check($sformatf("vec%0d_rd_data", i), chl_rd_data, tbl[i].x_rdd);
        end
        check("vec_err_clear", err_crd, 0);

        // Credit stall: three grants, then one write strobe buys exactly one more.
        do_reset("stall");
        req_valid = 4'h4;
        g = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (ready_s != 4'h0) g++;
        end
        check("stall_grants", g, 3);
        mon_lbus_en = 1'b1;
        cycle();
        check("stall_w_cycle_ready", ready_s, 4'h0);
        mon_lbus_en = 1'b0;
        cycle();
        check("stall_regrant_ready", ready_s, 4'h4);
        check("stall_regrant_valid", mst_rx_data_valid, 1);
        check("stall_regrant_data", mst_rx_data, 8'hA5);
        check("stall_regrant_chl", mst_rx_chl, 2);
        g = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (ready_s != 4'h0) g++;
        end
        check("stall_no_more_grants", g, 0);

        // Grant and write strobe together at credits == 1 leaves one credit.
        do_reset("simul");
        req_valid = 4'h2;
        cycle();
        cycle();
        mon_lbus_en = 1'b1;
        cycle();
        check("simul_grant_with_w", ready_s, 4'h2);
        mon_lbus_en = 1'b0;
        cycle();
        check("simul_next_grant", ready_s, 4'h2);
        cycle();
        check("simul_then_stall", ready_s, 4'h0);

        // Write strobe with a full buffer is an error and does not add a credit.
        do_reset("err");
        mon_lbus_en = 1'b1;
        cycle();
        mon_lbus_en = 1'b0;
        check("err_set", err_crd, 1);
        for (int i = 0; i < 3; i++) cycle();
        check("err_sticky", err_crd, 1);
        req_valid = 4'h1;
        g = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (ready_s != 4'h0) g++;
        end
        check("err_credits_full", g, 3);
        check("err_still_set", err_crd, 1);

        // Drain with two bytes outstanding, returned by two write strobes.
        do_reset("drain");
        req_valid = 4'h1;
        cycle();
        cycle();
        drain_req = 1'b1;
        cycle();
        check("drain_entry_no_grant", ready_s, 4'h0);
        g = 0;
        pulses = 0;
        first_pulse = -1;
        for (int i = 0; i < 8; i++) begin
            mon_lbus_en = (i < 2);
            cycle();
            if (ready_s != 4'h0) g++;
            if (drain_done) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
        check("drain_no_grants", g, 0);
        check("drain_done_pulses", pulses, 1);
        check("drain_done_timing", first_pulse, 2);
        check("drain_no_err", err_crd, 0);
        drain_req = 1'b0;
        g = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (ready_s != 4'h0) g++;
        end
        check("drain_resume_grants", g, 2);

        // Randomized traffic against a credit-count / rotating-priority model.
        do_reset("rand");
        m_cred  = 3;
        m_last  = 3;
        m_err   = 1'b0;
        exp_rxc = '0;
        exp_rxd = '0;
        exp_rdd = '0;
        for (int n = 0; n < 400; n++) begin
            chl_en            = 4'($urandom) | 4'($urandom);
            req_valid         = 4'($urandom) | 4'($urandom);
            req_data          = $urandom;
            mon_lbus_en       = ($urandom_range(0, 2) != 0);
            mon_lbus_op       = $urandom_range(0, 1) ? LBUS_OP_WR : 2'($urandom);
            mst_tx_data_valid = 1'($urandom);
            mst_tx_chl        = 2'($urandom);
            mst_tx_data       = 8'($urandom);
            chl_busy          = 4'($urandom) & 4'($urandom);

            elig = req_valid & chl_en;
            w = -1;
            if (m_cred > 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (w < 0 && elig[(m_last + k) % 4]) w = (m_last + k) % 4;
                end
            end
            exp_ready = (w >= 0) ? (4'h1 << w) : 4'h0;
            wr = mon_lbus_en && (mon_lbus_op == 2'b01);

            cycle();

            check("rand_ready", ready_s, exp_ready);
            check("rand_tx_busy", busy_s, |chl_busy);

            if (w >= 0) begin
                m_last  = w;
                exp_rxc = 2'(w);
                exp_rxd = req_data[8*w +: 8];
            end
            if (w >= 0 && !wr) m_cred--;
            else if (w < 0 && wr) begin
                if (m_cred == 3) m_err = 1'b1;
                else             m_cred++;
            end
            if (mst_tx_data_valid) exp_rdd = mst_tx_data;
            exp_rdv = mst_tx_data_valid ? (4'h1 << mst_tx_chl) : 4'h0;

            check("rand_rx_valid", mst_rx_data_valid, (w >= 0));
            if (w >= 0) begin
                check("rand_rx_chl", mst_rx_chl, exp_rxc);
                check("rand_rx_data", mst_rx_data, exp_rxd);
            end
            check("rand_rd_valid", chl_rd_valid, exp_rdv);
            check("rand_rd_data", chl_rd_data, exp_rdd);
            check("rand_err", err_crd, m_err);
            check("rand_drain_done", drain_done, 0);
        end

        do_reset("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
